spu_seq_controller: RTL
=======================

SPU_SEQ_CONTROLLER -- requirements
Module: spu_seq_controller

Interface
REQ-001 SHALL have parameter SPU_CYCLES, default 4, meaning SPU settle cycles before writeback; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Instruction  input  32  current instruction word; held stable by fetch logic between PCEn pulses.
REQ-005 SHALL have port ALUFlags  input  4  datapath flags {N,Z,C,V}.
REQ-006 SHALL have port PCEn  output  1  one-cycle PC update strobe.
REQ-007 SHALL have ports PCSrc, RegWrite, ALUSrc, MemtoReg  output  1 each  datapath selects/enables.
REQ-008 SHALL have ports RegSrc, ImmSrc  output  2 each  datapath selects.
REQ-009 SHALL have ports ALUControl  output  4; SPUCode  output  12; busy  output  1  high in every state except FETCH.

Function
REQ-010 SHALL decode op = Instruction[27:26]: 00 data-processing (DP), 01 memory, 10 branch, 11 SPU.
REQ-011 SHALL implement FSM states FETCH, DECODE, EXEC, SPU_RUN, WB.
REQ-012 SHALL transition FETCH->DECODE unconditionally; DECODE->FETCH if condition fails; DECODE->SPU_RUN for SPU; otherwise DECODE->EXEC.
REQ-013 SHALL transition EXEC->WB for DP and memory, EXEC->FETCH for branch.
REQ-014 SHALL transition SPU_RUN->WB when the cycle counter reaches SPU_CYCLES-1; counter clears on SPU_RUN entry.
REQ-015 SHALL transition WB->FETCH unconditionally.
REQ-016 SHALL evaluate ARM condition Instruction[31:28] (EQ..AL, code 1111 = never) against the internal flags register in DECODE.
REQ-017 SHALL update the flags register from ALUFlags at the end of EXEC only for DP with Instruction[20]=1 and passing condition.
REQ-018 SHALL drive ALUControl = Instruction[24:21] for DP and 4'b0100 (add) otherwise.
REQ-019 SHALL drive ALUSrc = Instruction[25] for DP and 1 for memory/branch.
REQ-020 SHALL drive ImmSrc = 00 for DP, 01 for memory, 10 for branch.
REQ-021 SHALL drive RegSrc = {memory, branch}.
REQ-022 SHALL drive SPUCode = Instruction[11:0] from SPU_RUN entry through WB; zero otherwise.
REQ-023 SHALL assert MemtoReg=1 only for SPU ops in SPU_RUN and WB.
REQ-024 SHALL assert RegWrite for exactly one cycle in WB; DP compare ops (funct 1010/1011) write nothing.
REQ-025 SHALL assert PCEn with PCSrc=0 in FETCH and with PCSrc=1 in branch EXEC.
REQ-026 SHALL assert PCEn at most once per instruction apart from the FETCH pulse; a failed condition yields only the FETCH pulse.

Reset
REQ-027 SHALL on reset, at any state including mid-SPU_RUN, enter FETCH and clear flags and counter to 0.
REQ-028 SHALL drive all outputs 0 while reset is high and in the first cycle after release, except busy, which is 0.

Structure
REQ-029 SHALL take the state enum, op codes (OP_DP, OP_MEM, OP_BR, OP_SPU), ALU add code and cond codes from shared package arm_ctrl_pkg.
REQ-030 SHALL isolate condition evaluation in sub-module cond_check (cond, flags -> pass).

Verification
REQ-031 DP ADDS, cond=1110, result zero -> RegWrite one cycle in WB, flags Z=1, 4 cycles/instruction.
REQ-032 Branch cond=0000 with Z=1 -> PCEn and PCSrc=1 in EXEC, no RegWrite, back to FETCH.
REQ-033 Branch cond=0000 with Z=0 -> only FETCH PCEn, DECODE->FETCH, no writes.
REQ-034 SPU op, SPU_CYCLES=4, Instruction[11:0]=0xA5C -> SPUCode=0xA5C for 4+1 cycles, MemtoReg=1, RegWrite in WB, 7 cycles total.
REQ-035 Reset asserted in 2nd SPU_RUN cycle -> next cycle FETCH, RegWrite never asserted, counter 0.
REQ-036 CMP (funct 1010, S=1) -> flags updated, RegWrite stays 0.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the SPU sequencing controller: FSM states, op classes,
// ALU add code and ARM condition codes.
package arm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_SPU_RUN,
        S_WB
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_SPU = 2'b11;

    localparam logic [3:0] ALU_ADD = 4'b0100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned CNT_W = 4;

    // CMP (1010) and CMN (1011) only set flags and never write a register.
    function automatic logic is_cmp_funct(input logic [3:0] funct);
        return funct[3:1] == 3'b101;
    endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the {N,Z,C,V} flags register.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass_c
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_flags;

    always_comb begin
        o_pass_c = 1'b0;
        case (i_cond)
            COND_EQ: o_pass_c = w_z;
            COND_NE: o_pass_c = !w_z;
            COND_CS: o_pass_c = w_c;
            COND_CC: o_pass_c = !w_c;
            COND_MI: o_pass_c = w_n;
            COND_PL: o_pass_c = !w_n;
            COND_VS: o_pass_c = w_v;
            COND_VC: o_pass_c = !w_v;
            COND_HI: o_pass_c = w_c && !w_z;
            COND_LS: o_pass_c = !w_c || w_z;
            COND_GE: o_pass_c = (w_n == w_v);
            COND_LT: o_pass_c = (w_n != w_v);
            COND_GT: o_pass_c = !w_z && (w_n == w_v);
            COND_LE: o_pass_c = w_z || (w_n != w_v);
            COND_AL: o_pass_c = 1'b1;
            COND_NV: o_pass_c = 1'b0;
            default: o_pass_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/spu_seq_controller.sv
// Multi-cycle ARM-style controller with an SPU pipeline stall; every output is
// registered from the next state, so it is valid for the whole state it belongs to.
module spu_seq_controller
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned SPU_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [3:0]  ALUFlags,
    output logic        PCEn,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic [11:0] SPUCode,
    output logic        busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_flags;
    logic             r_pcen, r_pcsrc, r_regwrite, r_alusrc, r_memtoreg, r_busy;
    logic [1:0]       r_regsrc, r_immsrc;
    logic [3:0]       r_aluctl;
    logic [11:0]      r_spucode;

    logic w_is_dp, w_is_mem, w_is_br, w_is_spu, w_is_cmp;
    logic w_pass, w_last, w_active, w_in_spu;
    logic [3:0] w_aluctl;
    logic [1:0] w_immsrc;
    logic w_alusrc;
    logic w_unused;

    // Register-number fields are consumed by the datapath, not the controller.
    assign w_unused = ^Instruction[19:12];

    assign w_is_dp  = (Instruction[27:26] == OP_DP);
    assign w_is_mem = (Instruction[27:26] == OP_MEM);
    assign w_is_br  = (Instruction[27:26] == OP_BR);
    assign w_is_spu = (Instruction[27:26] == OP_SPU);
    assign w_is_cmp = w_is_dp && is_cmp_funct(Instruction[24:21]);
    assign w_last   = (r_cnt == CNT_W'(SPU_CYCLES - 1));

    assign w_aluctl = w_is_dp ? Instruction[24:21] : ALU_ADD;
    assign w_alusrc = w_is_dp ? Instruction[25] : (w_is_mem || w_is_br);
    assign w_immsrc = w_is_mem ? 2'b01 : (w_is_br ? 2'b10 : 2'b00);

    cond_check u_cond (
        .i_cond   (Instruction[31:28]),
        .i_flags  (r_flags),
        .o_pass_c (w_pass)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:   w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (!w_pass)       w_state_nxt = S_FETCH;
                else if (w_is_spu) w_state_nxt = S_SPU_RUN;
                else               w_state_nxt = S_EXEC;
            end
            S_EXEC:    w_state_nxt = w_is_br ? S_FETCH : S_WB;
            S_SPU_RUN: if (w_last) w_state_nxt = S_WB;
            S_WB:      w_state_nxt = S_FETCH;
            default:   w_state_nxt = S_FETCH;
        endcase
    end

    assign w_active = (w_state_nxt != S_FETCH);
    assign w_in_spu = w_is_spu && (w_state_nxt == S_SPU_RUN || w_state_nxt == S_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_cnt      <= '0;
            r_flags    <= '0;
            r_pcen     <= 1'b0;
            r_pcsrc    <= 1'b0;
            r_regwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regsrc   <= '0;
            r_immsrc   <= '0;
            r_aluctl   <= '0;
            r_spucode  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Counter runs only inside SPU_RUN, so it is zero on every entry.
            r_cnt   <= (r_state == S_SPU_RUN && !w_last) ? r_cnt + CNT_W'(1) : '0;
            if (r_state == S_EXEC && w_is_dp && Instruction[20] && w_pass)
                r_flags <= ALUFlags;
            r_pcen     <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC && w_is_br);
            r_pcsrc    <= (w_state_nxt == S_EXEC) && w_is_br;
            r_regwrite <= (w_state_nxt == S_WB) && !w_is_cmp;
            r_memtoreg <= w_in_spu;
            r_spucode  <= w_in_spu ? Instruction[11:0] : 12'h000;
            r_busy     <= w_active;
            r_aluctl   <= w_active ? w_aluctl : 4'h0;
            r_alusrc   <= w_active && w_alusrc;
            r_immsrc   <= w_active ? w_immsrc : 2'b00;
            r_regsrc   <= w_active ? {w_is_mem, w_is_br} : 2'b00;
        end
    end

    assign PCEn       = r_pcen;
    assign PCSrc      = r_pcsrc;
    assign RegWrite   = r_regwrite;
    assign ALUSrc     = r_alusrc;
    assign MemtoReg   = r_memtoreg;
    assign RegSrc     = r_regsrc;
    assign ImmSrc     = r_immsrc;
    assign ALUControl = r_aluctl;
    assign SPUCode    = r_spucode;
    assign busy       = r_busy;

endmodule
